// File: rtl/zext_flag_pkg.sv
// Shared constants and the zero-extended flag legality check used by flag-stream consumers.
// Widths up to MAX_IN_W bits are handled by zero-extending the word before the check.
package zext_flag_pkg;
   localparam int IN_W_DEF    = 3;
   localparam int PACK_W_DEF  = 8;
   localparam int LEN_W       = $clog2(PACK_W_DEF + 1);
   localparam int ERR_CNT_MAX = 255;
   localparam int MAX_IN_W    = 64;

   // Legal: every bit above bit 0 is zero, or (optionally) the whole word is ones.
   function automatic logic is_legal_zext(input logic [MAX_IN_W-1:0] word,
                                          input int unsigned          width,
                                          input logic                 accept_sext);
      logic [MAX_IN_W-1:0] mask;
      logic [MAX_IN_W-1:0] masked;
      mask   = (width >= MAX_IN_W) ? '1 : ((MAX_IN_W'(1) << width) - MAX_IN_W'(1));
      masked = word & mask;
      return ((masked >> 1) == '0) || (accept_sext && (masked == mask));
   endfunction
endpackage

// File: rtl/zext_flag_narrow.sv
// Narrows one zero-extended flag word to its boolean value and flags illegal encodings.
// Purely combinational; no handshake of its own.
module zext_flag_narrow
   import zext_flag_pkg::*;
#(
   parameter int IN_W        = IN_W_DEF,
   parameter bit ACCEPT_SEXT = 1'b0
) (
   input  logic [IN_W-1:0] word,
   output logic            flag,
   output logic            illegal
);
   logic [MAX_IN_W-1:0] word_ext;

   assign word_ext = MAX_IN_W'(word);
   assign flag     = word[0];
   assign illegal  = ~is_legal_zext(word_ext, unsigned'(IN_W), ACCEPT_SEXT);
endmodule

// File: rtl/zext_bool_flag_packer.sv
// Packs narrowed flags into PACK_W-bit words, first flag in bit 0; 1-cycle latency to dataOut_vld.
// Input stalls only while a finished word sits unaccepted in the output register.
module zext_bool_flag_packer
   import zext_flag_pkg::*;
#(
   parameter int IN_W        = IN_W_DEF,
   parameter int PACK_W      = PACK_W_DEF,
   parameter bit ACCEPT_SEXT = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [IN_W-1:0]              dataIn_data,
   input  logic                         dataIn_last,
   input  logic                         dataIn_vld,
   output logic                         dataIn_rd,
   output logic [PACK_W-1:0]            dataOut_data,
   output logic [$clog2(PACK_W+1)-1:0]  dataOut_len,
   output logic                         dataOut_vld,
   input  logic                         dataOut_rd,
   output logic                         err,
   output logic [7:0]                   err_cnt
);
   localparam int LW = $clog2(PACK_W + 1);

   logic              flag;
   logic              illegal;
   logic              xfer;
   logic              complete;
   logic [PACK_W-1:0] acc;
   logic [PACK_W-1:0] acc_next;
   logic [LW-1:0]     fill_cnt;

   zext_flag_narrow #(
      .IN_W        (IN_W),
      .ACCEPT_SEXT (ACCEPT_SEXT)
   ) u_narrow (
      .word    (dataIn_data),
      .flag    (flag),
      .illegal (illegal)
   );

   assign dataIn_rd = rst_n & (~dataOut_vld | dataOut_rd);
   assign xfer      = dataIn_vld & dataIn_rd;
   assign complete  = xfer & (dataIn_last | (fill_cnt == LW'(PACK_W - 1)));
   // Bits above fill_cnt are always zero, so OR-ing in the new flag is enough.
   assign acc_next  = acc | (PACK_W'(flag) << fill_cnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc          <= '0;
         fill_cnt     <= '0;
         dataOut_data <= '0;
         dataOut_len  <= '0;
         dataOut_vld  <= 1'b0;
         err          <= 1'b0;
         err_cnt      <= '0;
      end else begin
         if (complete) begin
            dataOut_data <= acc_next;
            dataOut_len  <= fill_cnt + LW'(1);
            dataOut_vld  <= 1'b1;
         end else if (dataOut_rd) begin
            dataOut_vld  <= 1'b0;
         end

         if (xfer) begin
            if (complete) begin
               acc      <= '0;
               fill_cnt <= '0;
            end else begin
               acc      <= acc_next;
               fill_cnt <= fill_cnt + LW'(1);
            end
         end

         if (xfer && illegal) begin
            err <= 1'b1;
            if (err_cnt != 8'(ERR_CNT_MAX))
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_zext_bool_flag_packer.sv
// Directed bench for zext_bool_flag_packer (IN_W=3, PACK_W=8), plus an ACCEPT_SEXT=1 instance.
module tb_zext_bool_flag_packer;
   logic        clk;
   logic        rst_n;
   logic [2:0]  din_data;
   logic        din_last;
   logic        din_vld;
   logic        din_rd;
   logic [7:0]  dout_data;
   logic [3:0]  dout_len;
   logic        dout_vld;
   logic        dout_rd;
   logic        err;
   logic [7:0]  err_cnt;

   logic [2:0]  s_data;
   logic        s_last;
   logic        s_vld;
   logic        s_rd;
   logic [7:0]  s_out_data;
   logic [3:0]  s_out_len;
   logic        s_out_vld;
   logic        s_out_rd;
   logic        s_err;
   logic [7:0]  s_err_cnt;

   int checks = 0;
   int passed = 0;
   logic [11:0] got_q[$];
   logic [11:0] exp_q[$];

   zext_bool_flag_packer #(.IN_W(3), .PACK_W(8), .ACCEPT_SEXT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .dataIn_data(din_data), .dataIn_last(din_last), .dataIn_vld(din_vld), .dataIn_rd(din_rd),
      .dataOut_data(dout_data), .dataOut_len(dout_len), .dataOut_vld(dout_vld),
      .dataOut_rd(dout_rd), .err(err), .err_cnt(err_cnt)
   );

   zext_bool_flag_packer #(.IN_W(3), .PACK_W(8), .ACCEPT_SEXT(1'b1)) dut_sext (
      .clk(clk), .rst_n(rst_n),
      .dataIn_data(s_data), .dataIn_last(s_last), .dataIn_vld(s_vld), .dataIn_rd(s_rd),
      .dataOut_data(s_out_data), .dataOut_len(s_out_len), .dataOut_vld(s_out_vld),
      .dataOut_rd(s_out_rd), .err(s_err), .err_cnt(s_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every word the sink accepts (transfer happens at the following rising edge).
   always @(negedge clk)
      if (rst_n && dout_vld && dout_rd)
         got_q.push_back({dout_len, dout_data});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Presents one flag and returns 1 ns after the edge that accepted it.
   task automatic send(input logic [2:0] w, input logic l, input bit rnd_rd);
      bit ok;
      int n;
      din_data = w;
      din_last = l;
      din_vld  = 1'b1;
      n = 0;
      do begin
         if (rnd_rd) dout_rd = ($urandom_range(3) != 0);
         @(negedge clk);
         ok = din_rd;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      din_vld  = 1'b0;
      din_last = 1'b0;
   endtask

   initial begin
      logic [2:0]  t1 [8];
      logic [19:0] pat4;
      logic [7:0]  pat5;
      logic [7:0]  m_acc;
      int          m_cnt;
      int          ill;
      logic [2:0]  w;
      logic        l;

      rst_n = 1'b0; din_data = '0; din_last = 1'b0; din_vld = 1'b0; dout_rd = 1'b1;
      s_data = '0; s_last = 1'b0; s_vld = 1'b0; s_out_rd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", dout_vld, 0);
      check("rst_data", dout_data, 0);
      check("rst_len", dout_len, 0);
      check("rst_err", err, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_in_rd", din_rd, 0);
      rst_n = 1'b1;

      // Full word, no stall
      t1 = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
      for (int i = 0; i < 7; i++) send(t1[i], 1'b0, 1'b0);
      check("t1_no_early_vld", dout_vld, 0);
      send(t1[7], 1'b0, 1'b0);
      check("t1_vld", dout_vld, 1);
      check("t1_data", dout_data, 8'h4D);
      check("t1_len", dout_len, 8);
      check("t1_err", err, 0);

      // Partial words via last, back to back
      send(3'b001, 1'b0, 1'b0);
      send(3'b001, 1'b0, 1'b0);
      send(3'b000, 1'b1, 1'b0);
      check("t2a_data", dout_data, 8'h03);
      check("t2a_len", dout_len, 3);
      send(3'b001, 1'b1, 1'b0);
      check("t2b_vld", dout_vld, 1);
      check("t2b_data", dout_data, 8'h01);
      check("t2b_len", dout_len, 1);
      @(posedge clk); #1;
      check("t2_drained", dout_vld, 0);

      // Illegal encodings
      send(3'b010, 1'b0, 1'b0);
      check("t3_err", err, 1);
      check("t3_err_cnt1", err_cnt, 1);
      send(3'b101, 1'b1, 1'b0);
      check("t3_err_cnt2", err_cnt, 2);
      check("t3_data", dout_data, 8'h02);
      check("t3_len", dout_len, 2);
      send(3'b111, 1'b1, 1'b0);
      check("t3_nosext_cnt", err_cnt, 3);
      check("t3_nosext_data", dout_data, 8'h01);

      s_data = 3'b111; s_last = 1'b1; s_vld = 1'b1;
      @(posedge clk); #1;
      s_vld = 1'b0;
      check("sext_vld", s_out_vld, 1);
      check("sext_data", s_out_data, 8'h01);
      check("sext_err", s_err, 0);
      s_data = 3'b010; s_vld = 1'b1;
      @(posedge clk); #1;
      s_vld = 1'b0;
      check("sext_illegal_err", s_err, 1);
      check("sext_illegal_data", s_out_data, 8'h00);
      check("sext_illegal_len", s_out_len, 1);

      // Back-pressure across 20 flags
      @(posedge clk); #1;
      got_q.delete();
      dout_rd = 1'b0;
      pat4 = 20'h5C3B6;
      for (int i = 0; i < 8; i++) send({2'b00, pat4[i]}, 1'b0, 1'b0);
      din_data = {2'b00, pat4[8]}; din_last = 1'b0; din_vld = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t4_in_rd_low", din_rd, 0);
      check("t4_hold_vld", dout_vld, 1);
      check("t4_hold_data", dout_data, 8'hB6);
      check("t4_hold_len", dout_len, 8);
      dout_rd = 1'b1;
      for (int i = 8; i < 20; i++) send({2'b00, pat4[i]}, (i == 19), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t4_word_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("t4_word1", got_q[0], {4'd8, 8'hB6});
         check("t4_word2", got_q[1], {4'd8, 8'hC3});
         check("t4_word3", got_q[2], {4'd4, 8'h05});
      end

      // Reset with a pending word, then with a partial word
      got_q.delete();
      dout_rd = 1'b0;
      for (int i = 0; i < 8; i++) send(3'b001, 1'b0, 1'b0);
      check("t5_pending", dout_vld, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t5_rst_vld", dout_vld, 0);
      check("t5_rst_data", dout_data, 0);
      check("t5_rst_len", dout_len, 0);
      check("t5_rst_err", err, 0);
      check("t5_rst_err_cnt", err_cnt, 0);
      check("t5_rst_in_rd", din_rd, 0);
      rst_n = 1'b1;
      dout_rd = 1'b1;
      for (int i = 0; i < 5; i++) send(3'b001, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      pat5 = 8'h50;
      for (int i = 0; i < 8; i++) send({2'b00, pat5[i]}, 1'b0, 1'b0);
      check("t5_fresh_data", dout_data, 8'h50);
      check("t5_fresh_len", dout_len, 8);
      repeat (2) @(posedge clk);
      #1;
      check("t5_word_count", got_q.size(), 1);
      if (got_q.size() == 1) check("t5_word", got_q[0], {4'd8, 8'h50});

      // Randomised handshake against a scoreboard
      got_q.delete();
      exp_q.delete();
      m_acc = '0; m_cnt = 0; ill = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(3) == 0) begin
            dout_rd = ($urandom_range(1) != 0);
            @(posedge clk); #1;
         end
         if ($urandom_range(99) < 5) begin
            w = 3'($urandom_range(7, 2));
            ill++;
         end else begin
            w = {2'b00, 1'($urandom_range(1))};
         end
         l = (i == 1999) || ($urandom_range(9) == 0);
         send(w, l, 1'b1);
         m_acc[m_cnt] = w[0];
         m_cnt++;
         if (l || m_cnt == 8) begin
            exp_q.push_back({4'(m_cnt), m_acc});
            m_acc = '0;
            m_cnt = 0;
         end
      end
      dout_rd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t6_word_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check("t6_word", got_q[i], exp_q[i]);
      check("t6_err_cnt", err_cnt, (ill > 255) ? 255 : ill);
      check("t6_err", err, (ill != 0) ? 1 : 0);

      for (int i = 0; i < 300; i++) send(3'b100, 1'b0, 1'b0);
      check("t6_err_cnt_sat", err_cnt, 255);
      check("t6_err_sticky", err, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
